// File: rtl/sa_row_drain.sv
// sa_row_drain: captures a systolic-array result tile plus per-column bias,
// then streams it out one biased, saturated row per valid/ready transfer.
//
// Ports:
//   I_CLK       clock, all state on the rising edge
//   I_SYNC_RST  synchronous active-high reset
//   I_OUT_VLD   level valid from the array wrapper (rising edge = new tile)
//   I_OUT       result tile [SA_R][SA_C] of D_W-bit signed elements
//   I_BIAS      per-column signed bias [SA_C]
//   I_ROW_RDY   downstream ready
//   O_ROW_VLD   row valid (high in S_SEND)
//   O_ROW       biased, saturated row [SA_C]
//   O_ROW_IDX   index of the row on O_ROW
//   O_LAST      high with O_ROW_VLD on the final row
//   O_BUSY      high in S_SEND and S_DONE
//   O_DONE      one-cycle pulse after the last row transfers
//   O_DROP      one-cycle pulse when a tile arrives while busy
module sa_row_drain #(
    parameter int D_W  = 8,
    parameter int SA_R = 16,
    parameter int SA_C = 16
) (
    input  logic                                  I_CLK,
    input  logic                                  I_SYNC_RST,
    input  logic                                  I_OUT_VLD,
    input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]    I_OUT,
    input  logic [SA_C-1:0][D_W-1:0]              I_BIAS,
    input  logic                                  I_ROW_RDY,
    output logic                                  O_ROW_VLD,
    output logic [SA_C-1:0][D_W-1:0]              O_ROW,
    output logic [$clog2(SA_R)-1:0]               O_ROW_IDX,
    output logic                                  O_LAST,
    output logic                                  O_BUSY,
    output logic                                  O_DONE,
    output logic                                  O_DROP
);

    localparam int IDX_W = $clog2(SA_R);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);
    localparam logic [D_W-1:0] SAT_MAX = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [D_W-1:0] SAT_MIN = {1'b1, {(D_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_SEND = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t                              r_state;
    state_t                              w_next;
    logic                                r_vld_d;
    logic [IDX_W-1:0]                    r_idx;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]  r_buf;
    logic [SA_C-1:0][D_W-1:0]            r_bias;

    logic w_arrive;
    logic w_idle;
    logic w_send;
    logic w_done;
    logic w_capture;
    logic w_xfer;
    logic w_last;

    assign w_idle    = (r_state == S_IDLE);
    assign w_send    = (r_state == S_SEND);
    assign w_done    = (r_state == S_DONE);
    // Only a low-to-high edge of the level valid counts as a new tile.
    assign w_arrive  = I_OUT_VLD & ~r_vld_d;
    assign w_capture = w_arrive & w_idle;
    assign w_xfer    = w_send & I_ROW_RDY;
    assign w_last    = (r_idx == LAST_IDX);

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            r_state <= S_IDLE;
            // Reset to 1 so a valid still held high after reset is not
            // mistaken for a fresh tile.
            r_vld_d <= 1'b1;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_vld_d <= I_OUT_VLD;
            if (w_capture) begin
                r_idx <= '0;
            end else if (w_xfer) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Data buffers carry no reset; they are only observed while valid.
    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RST && w_capture) begin
            r_buf  <= I_OUT;
            r_bias <= I_BIAS;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Row datapath: sign-extend to D_W+1 bits, add, clamp on overflow.
    // Overflow shows up as the two top sum bits disagreeing; the
    // extension bit then gives the true sign.
    always_comb begin
        logic [D_W:0] w_sum;
        O_ROW = '0;
        w_sum = '0;
        for (int c = 0; c < SA_C; c++) begin
            w_sum = {r_buf[r_idx][c][D_W-1], r_buf[r_idx][c]}
                  + {r_bias[c][D_W-1], r_bias[c]};
            if (w_sum[D_W] != w_sum[D_W-1]) begin
                O_ROW[c] = w_sum[D_W] ? SAT_MIN : SAT_MAX;
            end else begin
                O_ROW[c] = w_sum[D_W-1:0];
            end
        end
    end

    assign O_ROW_VLD = w_send;
    assign O_ROW_IDX = r_idx;
    assign O_LAST    = w_send & w_last;
    assign O_BUSY    = w_send | w_done;
    assign O_DONE    = w_done;
    assign O_DROP    = w_arrive & (w_send | w_done) & ~I_SYNC_RST;

endmodule

// File: tb/tb_sa_row_drain.sv
// tb_sa_row_drain: self-checking bench for sa_row_drain using a row
// scoreboard, a saturation vector table and directed corner sequences.
module tb_sa_row_drain;

    localparam int D_W  = 8;
    localparam int SA_R = 16;
    localparam int SA_C = 16;

    logic                                  clk;
    logic                                  rst;
    logic                                  out_vld;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]    t_out;
    logic [SA_C-1:0][D_W-1:0]              t_bias;
    logic                                  rdy;
    logic                                  row_vld;
    logic [SA_C-1:0][D_W-1:0]              row;
    logic [3:0]                            row_idx;
    logic                                  last;
    logic                                  busy;
    logic                                  done;
    logic                                  drop;

    sa_row_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
        .I_CLK      (clk),
        .I_SYNC_RST (rst),
        .I_OUT_VLD  (out_vld),
        .I_OUT      (t_out),
        .I_BIAS     (t_bias),
        .I_ROW_RDY  (rdy),
        .O_ROW_VLD  (row_vld),
        .O_ROW      (row),
        .O_ROW_IDX  (row_idx),
        .O_LAST     (last),
        .O_BUSY     (busy),
        .O_DONE     (done),
        .O_DROP     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]               idx;
        logic [SA_C-1:0][D_W-1:0] row;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int y;
    } vec_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   drop_cnt = 0;
    int   xfer_cnt = 0;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic logic [D_W-1:0] sat8(input int a, input int b);
        int s;
        s = a + b;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return D_W'(s);
    endfunction

    task automatic push_model();
        exp_t e;
        for (int r = 0; r < SA_R; r++) begin
            e.idx = 4'(r);
            for (int c = 0; c < SA_C; c++)
                e.row[c] = sat8(int'($signed(t_out[r][c])),
                                int'($signed(t_bias[c])));
            q.push_back(e);
        end
    endtask

    task automatic push_const(input int y);
        exp_t e;
        for (int r = 0; r < SA_R; r++) begin
            e.idx = 4'(r);
            for (int c = 0; c < SA_C; c++)
                e.row[c] = D_W'(y);
            q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_tile();
        out_vld = 1'b0;
        step(1);
        out_vld = 1'b1;
        step(1);
    endtask

    task automatic fill_random();
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                t_out[r][c] = D_W'($urandom);
        for (int c = 0; c < SA_C; c++)
            t_bias[c] = D_W'($urandom);
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (k < 300 && (q.size() != 0 || busy)) begin
            step(1);
            k++;
        end
        chk(q.size() == 0 && !busy, nm, q.size(), 0);
    endtask

    // Monitor: every valid row is compared against the scoreboard head,
    // so a stalled row must hold its value until it transfers.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (drop) drop_cnt++;
            if (row_vld) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_row", row_idx, -1);
                end else begin
                    chk(row_idx == q[0].idx, "row_idx", row_idx, q[0].idx);
                    checks++;
                    if (row !== q[0].row) begin
                        failures++;
                        $display("FAIL row_data idx %0d: got %h expected %h",
                                 q[0].idx, row, q[0].row);
                    end
                    chk(last == (q[0].idx == 4'd15), "last",
                        last, q[0].idx == 4'd15);
                    if (rdy) begin
                        void'(q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        vec_t vt[8];
        bit   pat[4];
        int   d0;
        int   x0;
        int   k;

        vt[0] = '{100, 100, 127};
        vt[1] = '{-100, -100, -128};
        vt[2] = '{5, -7, -2};
        vt[3] = '{127, 0, 127};
        vt[4] = '{-128, -1, -128};
        vt[5] = '{64, 63, 127};
        vt[6] = '{-64, -65, -128};
        vt[7] = '{-1, 1, 0};
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;

        rst     = 1'b1;
        out_vld = 1'b1;
        rdy     = 1'b1;
        t_out   = '0;
        t_bias  = '0;
        step(3);
        chk(row_vld == 0, "rst_vld", row_vld, 0);
        chk(busy == 0, "rst_busy", busy, 0);
        chk(done == 0, "rst_done", done, 0);
        chk(drop == 0, "rst_drop", drop, 0);
        chk(last == 0, "rst_last", last, 0);
        rst = 1'b0;
        step(5);
        chk(busy == 0, "no_capture_after_rst", busy, 0);

        // Identity drain with explicit latency and pulse timing.
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                t_out[r][c] = D_W'(r);
        t_bias = '0;
        push_model();
        d0 = done_cnt;
        send_tile();
        for (int i = 0; i < SA_R; i++) begin
            @(negedge clk);
            chk(row_vld == 1, "id_vld", row_vld, 1);
            chk(row_idx == 4'(i), "id_idx", row_idx, i);
        end
        @(negedge clk);
        chk(done == 1, "id_done", done, 1);
        chk(row_vld == 0, "id_vld_off", row_vld, 0);
        @(negedge clk);
        chk(done == 0, "id_done_1cyc", done, 0);
        chk(busy == 0, "id_idle", busy, 0);
        @(posedge clk);
        #1;
        chk(done_cnt - d0 == 1, "id_done_cnt", done_cnt - d0, 1);

        // Saturation table.
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < SA_R; r++)
                for (int c = 0; c < SA_C; c++)
                    t_out[r][c] = D_W'(vt[v].a);
            for (int c = 0; c < SA_C; c++)
                t_bias[c] = D_W'(vt[v].b);
            push_const(vt[v].y);
            d0 = done_cnt;
            send_tile();
            wait_drain("sat_drain");
            step(1);
            chk(done_cnt - d0 == 1, "sat_done_cnt", done_cnt - d0, 1);
        end

        // Backpressure 1,0,0,1.
        fill_random();
        push_model();
        d0 = done_cnt;
        x0 = xfer_cnt;
        send_tile();
        k = 0;
        while (k < 400 && busy) begin
            rdy = pat[k % 4];
            step(1);
            k++;
        end
        rdy = 1'b1;
        chk(!busy, "bp_timeout", busy, 0);
        chk(xfer_cnt - x0 == 16, "bp_xfers", xfer_cnt - x0, 16);
        chk(done_cnt - d0 == 1, "bp_done_cnt", done_cnt - d0, 1);
        chk(q.size() == 0, "bp_queue", q.size(), 0);

        // Collision during row 5, with new data on the inputs.
        fill_random();
        push_model();
        d0 = done_cnt;
        x0 = drop_cnt;
        send_tile();
        step(4);
        out_vld = 1'b0;
        step(1);
        out_vld = 1'b1;
        fill_random();
        @(negedge clk);
        chk(drop == 1, "col_drop", drop, 1);
        chk(row_idx == 4'd5, "col_row5", row_idx, 5);
        @(negedge clk);
        chk(drop == 0, "col_drop_1cyc", drop, 0);
        @(posedge clk);
        #1;
        wait_drain("col_drain");
        step(3);
        chk(drop_cnt - x0 == 1, "col_drop_cnt", drop_cnt - x0, 1);
        chk(done_cnt - d0 == 1, "col_done_cnt", done_cnt - d0, 1);

        // Sticky valid for 100 cycles.
        fill_random();
        push_model();
        d0 = done_cnt;
        send_tile();
        step(100);
        chk(done_cnt - d0 == 1, "sticky_done_cnt", done_cnt - d0, 1);
        chk(q.size() == 0, "sticky_queue", q.size(), 0);
        chk(busy == 0, "sticky_idle", busy, 0);

        // Reset mid-drain at row 7 with valid held high.
        fill_random();
        push_model();
        d0 = done_cnt;
        send_tile();
        step(7);
        chk(row_idx == 4'd7, "rmd_row7", row_idx, 7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk(row_vld == 0, "rmd_vld", row_vld, 0);
        chk(busy == 0, "rmd_busy", busy, 0);
        @(posedge clk);
        #1;
        step(20);
        chk(done_cnt - d0 == 0, "rmd_no_done", done_cnt - d0, 0);
        chk(busy == 0, "rmd_no_recap", busy, 0);
        fill_random();
        push_model();
        send_tile();
        wait_drain("rmd_new_drain");
        step(1);
        chk(done_cnt - d0 == 1, "rmd_new_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
